exti_pending_ctrl: RTL and testbench

//  Back end of the EXTI path. Receives per-line edge pulses from the edge detector.

---
 rtl/exti_pkg.sv | 16 +
 rtl/exti_line_cell.sv | 81 ++++++++
 rtl/exti_pending_ctrl.sv | 144 ++++++++++++++
 tb/tb_exti_pending_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/exti_pkg.sv
// exti_pkg: shared constants for the EXTI pending/mask controller.
//   DATA_W          register port data width
//   N_LINES_DEFAULT default number of EXTI lines
//   ADDR_*          register index map for reg_addr (6 and 7 are unmapped)
package exti_pkg;
  localparam int DATA_W          = 32;
  localparam int N_LINES_DEFAULT = 21;
  localparam int ADDR_W          = 3;

  localparam logic [ADDR_W-1:0] ADDR_IMR   = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_EMR   = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_SWIER = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_PR    = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_RTSR  = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_FTSR  = 3'd5;
endpackage

// File: rtl/exti_line_cell.sv
// exti_line_cell: state for a single EXTI line.
//   Holds the pending bit and software-trigger bit, applies set-over-clear
//   priority on the pending bit, gates the interrupt request with the mask
//   and (when EXTI_EVT_EN is defined) registers the one-cycle event pulse.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_emr         event mask bit (present only with EXTI_EVT_EN)
//   i_edge        one-cycle edge pulse from the edge detector
//   i_swier_we    write strobe targeting SWIER
//   i_swier_wbit  this line's SWIER write data bit
//   i_pr_clr      write-1-to-clear of this line's pending bit
//   i_imr         interrupt mask bit
//   o_pr, o_swier current pending / software-trigger bits
//   o_irq         level interrupt request (pending & mask)
//   o_evt         one-cycle event pulse (constant 0 without EXTI_EVT_EN)
// Configuration macro: EXTI_EVT_EN
module exti_line_cell (
  input  logic clk,
  input  logic rst,
`ifdef EXTI_EVT_EN
  input  logic i_emr,
`endif
  input  logic i_edge,
  input  logic i_swier_we,
  input  logic i_swier_wbit,
  input  logic i_pr_clr,
  input  logic i_imr,
  output logic o_pr,
  output logic o_swier,
  output logic o_irq,
  output logic o_evt
);
  logic r_pr;
  logic r_swier;
  logic w_swier_rise;
  logic w_trig;

  // Only a 0->1 transition of SWIER triggers; rewriting 1 is a no-op.
  assign w_swier_rise = i_swier_we & i_swier_wbit & ~r_swier;
  assign w_trig       = i_edge | w_swier_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pr    <= 1'b0;
      r_swier <= 1'b0;
    end else begin
      // A new trigger beats a simultaneous clear so no event is lost.
      if (w_trig) begin
        r_pr <= 1'b1;
      end else if (i_pr_clr) begin
        r_pr <= 1'b0;
      end
      // SWIER only ever clears through the pending-register clear.
      if (i_pr_clr) begin
        r_swier <= 1'b0;
      end else if (w_swier_rise) begin
        r_swier <= 1'b1;
      end
    end
  end

  assign o_pr    = r_pr;
  assign o_swier = r_swier;
  assign o_irq   = r_pr & i_imr;

`ifdef EXTI_EVT_EN
  logic r_evt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_evt <= 1'b0;
    end else begin
      r_evt <= w_trig & i_emr;
    end
  end

  assign o_evt = r_evt;
`else
  assign o_evt = 1'b0;
`endif
endmodule

// File: rtl/exti_pending_ctrl.sv
// exti_pending_ctrl: back end of the EXTI path.
//   Latches edge pulses and software triggers into the pending register,
//   drives masked interrupt requests and holds the trigger-select and mask
//   registers behind a simple register port with one-cycle read latency.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   edge_detected         per-line one-cycle edge pulses
//   reg_we/reg_re         register write / read strobes
//   reg_addr, reg_wdata   register index and write data
//   reg_rdata, reg_rvalid read data (0 when not valid) and valid pulse
//   exti_rtsr, exti_ftsr  trigger selects to the edge detector
//   irq_req               level interrupt requests to the NVIC
//   evt_pulse             one-cycle event pulses
// Configuration macro: EXTI_EVT_EN (implements EMR and event pulses).
module exti_pending_ctrl
  import exti_pkg::*;
#(
  parameter int N_LINES = N_LINES_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_LINES-1:0] edge_detected,
  input  logic               reg_we,
  input  logic               reg_re,
  input  logic [ADDR_W-1:0]  reg_addr,
  input  logic [DATA_W-1:0]  reg_wdata,
  output logic [DATA_W-1:0]  reg_rdata,
  output logic               reg_rvalid,
  output logic [N_LINES-1:0] exti_rtsr,
  output logic [N_LINES-1:0] exti_ftsr,
  output logic [N_LINES-1:0] irq_req,
  output logic [N_LINES-1:0] evt_pulse
);
  logic [N_LINES-1:0] r_imr;
  logic [N_LINES-1:0] r_rtsr;
  logic [N_LINES-1:0] r_ftsr;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_rvalid;

  logic [N_LINES-1:0] w_wdata;
  logic [N_LINES-1:0] w_pr;
  logic [N_LINES-1:0] w_swier;
  logic [N_LINES-1:0] w_rd_lines;
  logic [DATA_W-1:0]  w_rd_word;
  logic               w_we_imr;
  logic               w_we_swier;
  logic               w_we_pr;
  logic               w_we_rtsr;
  logic               w_we_ftsr;
  // Data bits above N_LINES are intentionally dropped.
  logic               w_unused_wdata;

  assign w_wdata        = reg_wdata[N_LINES-1:0];
  assign w_unused_wdata = ^reg_wdata;

  assign w_we_imr   = reg_we & (reg_addr == ADDR_IMR);
  assign w_we_swier = reg_we & (reg_addr == ADDR_SWIER);
  assign w_we_pr    = reg_we & (reg_addr == ADDR_PR);
  assign w_we_rtsr  = reg_we & (reg_addr == ADDR_RTSR);
  assign w_we_ftsr  = reg_we & (reg_addr == ADDR_FTSR);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_imr  <= '0;
      r_rtsr <= '0;
      r_ftsr <= '0;
    end else begin
      if (w_we_imr)  r_imr  <= w_wdata;
      if (w_we_rtsr) r_rtsr <= w_wdata;
      if (w_we_ftsr) r_ftsr <= w_wdata;
    end
  end

`ifdef EXTI_EVT_EN
  logic [N_LINES-1:0] r_emr;
  logic               w_we_emr;

  assign w_we_emr = reg_we & (reg_addr == ADDR_EMR);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_emr <= '0;
    end else if (w_we_emr) begin
      r_emr <= w_wdata;
    end
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N_LINES; gi++) begin : g_line
      exti_line_cell u_cell (
        .clk          (clk),
        .rst          (rst),
`ifdef EXTI_EVT_EN
        .i_emr        (r_emr[gi]),
`endif
        .i_edge       (edge_detected[gi]),
        .i_swier_we   (w_we_swier),
        .i_swier_wbit (w_wdata[gi]),
        .i_pr_clr     (w_we_pr & w_wdata[gi]),
        .i_imr        (r_imr[gi]),
        .o_pr         (w_pr[gi]),
        .o_swier      (w_swier[gi]),
        .o_irq        (irq_req[gi]),
        .o_evt        (evt_pulse[gi])
      );
    end
  endgenerate

  // Read mux samples current (pre-write) state, so a same-cycle write
  // to the read address is not visible in the returned data.
  always_comb begin
    w_rd_lines = '0;
    case (reg_addr)
      ADDR_IMR:   w_rd_lines = r_imr;
`ifdef EXTI_EVT_EN
      ADDR_EMR:   w_rd_lines = r_emr;
`endif
      ADDR_SWIER: w_rd_lines = w_swier;
      ADDR_PR:    w_rd_lines = w_pr;
      ADDR_RTSR:  w_rd_lines = r_rtsr;
      ADDR_FTSR:  w_rd_lines = r_ftsr;
      default:    w_rd_lines = '0;
    endcase
    w_rd_word                = '0;
    w_rd_word[N_LINES-1:0]   = w_rd_lines;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= reg_re;
      r_rdata  <= reg_re ? w_rd_word : '0;
    end
  end

  assign reg_rdata  = r_rdata;
  assign reg_rvalid = r_rvalid;
  assign exti_rtsr  = r_rtsr;
  assign exti_ftsr  = r_ftsr;
endmodule

// File: tb/tb_exti_pending_ctrl.sv
// tb_exti_pending_ctrl: scoreboard bench for exti_pending_ctrl.
// Register reads push their expected word when issued; a negedge monitor
// pops and compares when reg_rvalid is seen. Level outputs are checked
// directly one cycle after the stimulus that should change them.
// Configuration macro: EXTI_EVT_EN (selects EMR/event expectations).
module tb_exti_pending_ctrl;
  localparam int N = 21;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  edge_detected;
  logic          reg_we;
  logic          reg_re;
  logic [2:0]    reg_addr;
  logic [31:0]   reg_wdata;
  logic [31:0]   reg_rdata;
  logic          reg_rvalid;
  logic [N-1:0]  exti_rtsr;
  logic [N-1:0]  exti_ftsr;
  logic [N-1:0]  irq_req;
  logic [N-1:0]  evt_pulse;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

`ifdef EXTI_EVT_EN
  localparam bit EVT_ON = 1'b1;
`else
  localparam bit EVT_ON = 1'b0;
`endif

  exti_pending_ctrl #(.N_LINES(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .edge_detected (edge_detected),
    .reg_we        (reg_we),
    .reg_re        (reg_re),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .reg_rdata     (reg_rdata),
    .reg_rvalid    (reg_rvalid),
    .exti_rtsr     (exti_rtsr),
    .exti_ftsr     (exti_ftsr),
    .irq_req       (irq_req),
    .evt_pulse     (evt_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end else begin
      n_pass++;
      $display("ok   %s 0x%08h", tag, got);
    end
  endtask

  // Read-data monitor: one compare per returned read, plus idle-zero check.
  always @(negedge clk) begin
    if (reg_rvalid) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", 32'd1, 32'd0);
      end else begin
        chk(tag_q.pop_front(), reg_rdata, exp_q.pop_front());
      end
    end else if (!rst && reg_rdata !== 32'd0) begin
      chk("rdata_idle_zero", reg_rdata, 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    step();
    reg_we = 1'b0; reg_wdata = '0;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] e);
    reg_re = 1'b1; reg_addr = a;
    exp_q.push_back(e); tag_q.push_back(tag);
    step();
    reg_re = 1'b0;
  endtask

  task automatic pulse(input logic [N-1:0] e);
    edge_detected = e;
    step();
    edge_detected = '0;
  endtask

  initial begin
    rst = 1'b1; edge_detected = '0; reg_we = 1'b0; reg_re = 1'b0;
    reg_addr = '0; reg_wdata = '0;
    step(); step();
    chk("rst_rvalid", {31'd0, reg_rvalid}, 32'd0);
    chk("rst_rdata", reg_rdata, 32'd0);
    chk("rst_irq", {11'd0, irq_req}, 32'd0);
    chk("rst_evt", {11'd0, evt_pulse}, 32'd0);
    rst = 1'b0;

    // 1: masked-in edge raises irq, W1C drops it
    wr(3'd0, 32'h1);
    pulse(21'h1);
    chk("t1_irq_set", {11'd0, irq_req}, 32'h1);
    rd("t1_pr", 3'd3, 32'h1);
    wr(3'd3, 32'h1);
    chk("t1_irq_clr", {11'd0, irq_req}, 32'h0);
    rd("t1_pr_clr", 3'd3, 32'h0);

    // 2: masked-out edge still pends; unmasking raises irq
    wr(3'd0, 32'h0);
    pulse(21'h20);
    chk("t2_irq_masked", {11'd0, irq_req}, 32'h0);
    rd("t2_pr", 3'd3, 32'h20);
    wr(3'd0, 32'h20);
    chk("t2_irq_unmask", {11'd0, irq_req}, 32'h20);
    wr(3'd3, 32'h20);
    wr(3'd0, 32'h0);

    // 3: software trigger, no retrigger, clears only via PR
    wr(3'd1, 32'h4);
    wr(3'd2, 32'h4);
    chk("t3_evt_sw", {11'd0, evt_pulse}, EVT_ON ? 32'h4 : 32'h0);
    rd("t3_pr", 3'd3, 32'h4);
    wr(3'd2, 32'h4);
    chk("t3_evt_noretrig", {11'd0, evt_pulse}, 32'h0);
    wr(3'd2, 32'h0);
    rd("t3_swier", 3'd2, 32'h4);
    wr(3'd3, 32'h4);
    rd("t3_pr_clr", 3'd3, 32'h0);
    rd("t3_swier_clr", 3'd2, 32'h0);
    wr(3'd1, 32'h0);

    // 4: set wins over simultaneous W1C
    pulse(21'h8);
    edge_detected = 21'h8;
    wr(3'd3, 32'h8);
    edge_detected = '0;
    rd("t4_pr_setwins", 3'd3, 32'h8);
    wr(3'd3, 32'h8);
    rd("t4_pr_clr", 3'd3, 32'h0);

    // 5: event pulse on line 20, exactly one cycle
    wr(3'd1, 32'h100000);
    rd("t5_emr", 3'd1, EVT_ON ? 32'h100000 : 32'h0);
    pulse(21'h100000);
    chk("t5_evt_on", {11'd0, evt_pulse}, EVT_ON ? 32'h100000 : 32'h0);
    step();
    chk("t5_evt_off", {11'd0, evt_pulse}, 32'h0);
    wr(3'd3, 32'h100000);

    // 6: trigger selects, width clipping, unmapped addresses, latency
    wr(3'd4, 32'h1FFFFF);
    chk("t6_rtsr_out", {11'd0, exti_rtsr}, 32'h1FFFFF);
    wr(3'd5, 32'hFFFF_FFFF);
    chk("t6_ftsr_out", {11'd0, exti_ftsr}, 32'h1FFFFF);
    reg_re = 1'b1; reg_addr = 3'd4;
    exp_q.push_back(32'h001FFFFF); tag_q.push_back("t6_rtsr_rd");
    step();
    reg_re = 1'b0;
    chk("t6_rvalid_hi", {31'd0, reg_rvalid}, 32'd1);
    step();
    chk("t6_rvalid_lo", {31'd0, reg_rvalid}, 32'd0);
    rd("t6_ftsr_rd", 3'd5, 32'h1FFFFF);
    rd("t6_addr6", 3'd6, 32'h0);
    wr(3'd7, 32'hFFFF_FFFF);
    rd("t6_addr7", 3'd7, 32'h0);
    // Read and write IMR in the same cycle returns the old value.
    reg_re = 1'b1; reg_we = 1'b1; reg_addr = 3'd0; reg_wdata = 32'h3;
    exp_q.push_back(32'h0); tag_q.push_back("t6_rw_old");
    step();
    reg_re = 1'b0; reg_we = 1'b0;
    rd("t6_rw_new", 3'd0, 32'h3);

    // Reset with pending requests and an in-flight read
    pulse(21'h3);
    chk("t6_irq_pre_rst", {11'd0, irq_req}, 32'h3);
    rst = 1'b1; reg_re = 1'b1; reg_addr = 3'd3;
    step();
    rst = 1'b0; reg_re = 1'b0;
    chk("t6_irq_rst", {11'd0, irq_req}, 32'h0);
    chk("t6_rvalid_rst", {31'd0, reg_rvalid}, 32'd0);
    rd("t6_pr_rst", 3'd3, 32'h0);
    rd("t6_imr_rst", 3'd0, 32'h0);
    rd("t6_rtsr_rst", 3'd4, 32'h0);

    // Drain scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    step();
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
